// File: rtl/bj_card_dispatcher_if.sv
// Game-side and generator-side signals of the blackjack card dispatcher.
// slave is the dispatcher's view; master is the game FSM / generator side.
interface bj_card_dispatcher_if;
    logic       new_round_i;
    logic       player_hit_i;
    logic       dealer_hit_i;
    logic       request_card_o;
    logic [7:0] card_i;
    logic [7:0] card_o;
    logic       card_valid_o;
    logic       card_dest_o;
    logic       player_ack_o;
    logic       dealer_ack_o;
    logic       deal_done_o;
    logic       busy_o;
    logic       err_o;
    logic [5:0] player_score_o;
    logic [5:0] dealer_score_o;
    logic       player_bust_o;
    logic       dealer_bust_o;

    modport slave (
        input  new_round_i, player_hit_i, dealer_hit_i, card_i,
        output request_card_o, card_o, card_valid_o, card_dest_o,
               player_ack_o, dealer_ack_o, deal_done_o, busy_o, err_o,
               player_score_o, dealer_score_o, player_bust_o, dealer_bust_o
    );

    modport master (
        output new_round_i, player_hit_i, dealer_hit_i, card_i,
        input  request_card_o, card_o, card_valid_o, card_dest_o,
               player_ack_o, dealer_ack_o, deal_done_o, busy_o, err_o,
               player_score_o, dealer_score_o, player_bust_o, dealer_bust_o
    );
endinterface

// File: rtl/bj_card_dispatcher.sv
// Shares one card generator between player and dealer: opening deal, then round-robin hits.
// Define SCORE_TRACK_EN to add per-side saturating hand totals and bust handling.
module bj_card_dispatcher #(
    parameter int CARD_LATENCY = 2,
    parameter int MAX_RETRY    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bj_card_dispatcher_if.slave  bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DELIVER = 3'd4;

    localparam logic [3:0] LAT_LOAD = 4'(CARD_LATENCY - 1);
    localparam int         RW       = $clog2(MAX_RETRY + 1) + 1;

    logic [2:0]    state;
    logic [3:0]    lat_cnt;
    logic [7:0]    hold;
    logic [RW-1:0] retry;
    logic          deal_act;
    logic [1:0]    slot;
    logic          job_deal;
    logic          job_dest;
    logic          rr;
    logic          err;

    logic rank_ok, round_go, pick_d, go_hit, nocard;
    logic p_bust, d_bust;

    assign rank_ok  = (hold[3:0] != 4'd0) && (hold[3:0] <= 4'd13);
    assign round_go = bus.new_round_i && !deal_act;
    // rr set means the dealer wins a tie; a lone requester always wins.
    assign pick_d   = bus.dealer_hit_i && (!bus.player_hit_i || rr);
    assign go_hit   = (state == IDLE) && !deal_act && !bus.new_round_i
                      && (bus.player_hit_i || bus.dealer_hit_i);
    assign nocard   = go_hit && (pick_d ? d_bust : p_bust);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            lat_cnt  <= 4'd0;
            hold     <= 8'd0;
            retry    <= '0;
            deal_act <= 1'b0;
            slot     <= 2'd0;
            job_deal <= 1'b0;
            job_dest <= 1'b0;
            rr       <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (round_go) begin
                deal_act <= 1'b1;
                slot     <= 2'd0;
                err      <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (deal_act) begin
                        job_deal <= 1'b1;
                        job_dest <= slot[0];
                        state    <= REQ;
                    end else if (go_hit) begin
                        rr <= ~pick_d;
                        if (!nocard) begin
                            job_deal <= 1'b0;
                            job_dest <= pick_d;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        hold  <= bus.card_i;
                        state <= CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    if (rank_ok) begin
                        state <= DELIVER;
                    end else if (retry == RW'(MAX_RETRY)) begin
                        // Give up on this slot; the whole deal goes with it.
                        err      <= 1'b1;
                        deal_act <= 1'b0;
                        retry    <= '0;
                        state    <= IDLE;
                    end else begin
                        retry <= retry + RW'(1);
                        state <= REQ;
                    end
                end
                DELIVER: begin
                    retry <= '0;
                    if (job_deal) begin
                        slot <= slot + 2'd1;
                        if (slot == 2'd3)
                            deal_act <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic deliver;
    assign deliver = (state == DELIVER);

    assign bus.request_card_o = (state == REQ);
    assign bus.card_valid_o   = deliver;
    assign bus.card_o         = deliver ? hold : 8'd0;
    assign bus.card_dest_o    = deliver && job_dest;
    assign bus.player_ack_o   = (deliver && !job_deal && !job_dest) || (nocard && !pick_d);
    assign bus.dealer_ack_o   = (deliver && !job_deal &&  job_dest) || (nocard &&  pick_d);
    assign bus.deal_done_o    = deliver && job_deal && (slot == 2'd3);
    assign bus.busy_o         = (state != IDLE);
    assign bus.err_o          = err;

`ifdef SCORE_TRACK_EN
    logic [5:0] p_score, d_score;
    logic [3:0] val;

    // Face cards count 10; the ace counts 1.
    always_comb val = (hold[3:0] >= 4'd10) ? 4'd10 : hold[3:0];

    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [3:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {3'b0, b};
        return s[6] ? 6'h3F : s[5:0];
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_score <= 6'd0;
            d_score <= 6'd0;
        end else if (round_go) begin
            p_score <= 6'd0;
            d_score <= 6'd0;
        end else if (deliver) begin
            if (job_dest) d_score <= sat_add(d_score, val);
            else          p_score <= sat_add(p_score, val);
        end
    end

    assign p_bust             = (p_score > 6'd21);
    assign d_bust             = (d_score > 6'd21);
    assign bus.player_score_o = p_score;
    assign bus.dealer_score_o = d_score;
    assign bus.player_bust_o  = p_bust;
    assign bus.dealer_bust_o  = d_bust;
`else
    assign p_bust             = 1'b0;
    assign d_bust             = 1'b0;
    assign bus.player_score_o = 6'd0;
    assign bus.dealer_score_o = 6'd0;
    assign bus.player_bust_o  = 1'b0;
    assign bus.dealer_bust_o  = 1'b0;
`endif

endmodule
